// File: rtl/baccarat_match_ctrl_pkg.sv
// ------------------------------------------------------------------
// baccarat_match_ctrl_pkg: shared states, result codes, helpers. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package baccarat_match_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    DEAL       = 3'd2,
    SETTLE     = 3'd3,
    SHOW       = 3'd4,
    MATCH_OVER = 3'd5,
    FAULT      = 3'd6
  } state_e;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_DEALER = 2'b01;
  localparam logic [1:0] RES_PLAYER = 2'b10;
  localparam logic [1:0] RES_TIE    = 2'b11;

  // Timer only has to hold 0..TIMEOUT-1.
  function automatic int timer_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/baccarat_match_ctrl_sat.sv
// ------------------------------------------------------------------
// sat_counter: clearable up-counter that sticks at all-ones. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/baccarat_match_ctrl.sv
// ------------------------------------------------------------------
// baccarat_match_ctrl: match sequencer above the per-hand FSM. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module baccarat_match_ctrl
  import baccarat_match_ctrl_pkg::*;
#(
  parameter int WIN_TARGET = 5,
  parameter int CNT_W      = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic             start,
  input  logic             next_round,
  input  logic             player_win_light,
  input  logic             dealer_win_light,
  output logic             hand_resetb,
  output logic [1:0]       last_result,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties,
  output logic [CNT_W-1:0] round_num,
  output logic             match_over,
  output logic [1:0]       match_winner,
  output logic             busy,
  output logic             fault
);

  localparam int               TMR_W      = timer_width(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(WIN_TARGET);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       last_result_q, last_result_d;
  logic [1:0]       match_winner_q, match_winner_d;
  logic [1:0]       result;
  logic             clr_all, inc_player, inc_dealer, inc_tie, inc_round;
  logic [CNT_W-1:0] player_post, dealer_post;

  assign result       = {player_win_light, dealer_win_light};
  assign last_result  = last_result_q;
  assign match_winner = match_winner_q;

  // Values the tallies will hold after this SETTLE edge, saturation included.
  assign player_post = (player_wins == {CNT_W{1'b1}}) ? player_wins : player_wins + CNT_W'(1);
  assign dealer_post = (dealer_wins == {CNT_W{1'b1}}) ? dealer_wins : dealer_wins + CNT_W'(1);

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      last_result_q  <= RES_NONE;
      match_winner_q <= RES_NONE;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      last_result_q  <= last_result_d;
      match_winner_q <= match_winner_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    last_result_d  = last_result_q;
    match_winner_d = match_winner_q;
    clr_all        = 1'b0;
    inc_player     = 1'b0;
    inc_dealer     = 1'b0;
    inc_tie        = 1'b0;
    inc_round      = 1'b0;
    hand_resetb    = 1'b0;
    busy           = 1'b0;
    match_over     = 1'b0;
    fault          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          clr_all        = 1'b1;
          last_result_d  = RES_NONE;
          match_winner_d = RES_NONE;
          state_d        = CLEAR;
        end
      end
      CLEAR: begin
        busy    = 1'b1;
        timer_d = '0;
        state_d = DEAL;
      end
      DEAL: begin
        hand_resetb = 1'b1;
        busy        = 1'b1;
        timer_d     = timer_q + TMR_W'(1);
        // A result arriving on the final watchdog cycle still counts.
        if (result != RES_NONE) begin
          last_result_d = result;
          state_d       = SETTLE;
        end else if (timer_q == TMR_LAST) begin
          state_d = FAULT;
        end
      end
      SETTLE: begin
        hand_resetb = 1'b1;
        busy        = 1'b1;
        inc_player  = (last_result_q == RES_PLAYER);
        inc_dealer  = (last_result_q == RES_DEALER);
        inc_tie     = (last_result_q == RES_TIE);
        inc_round   = 1'b1;
        if (inc_player && (player_post == CNT_TARGET)) begin
          match_winner_d = RES_PLAYER;
          state_d        = MATCH_OVER;
        end else if (inc_dealer && (dealer_post == CNT_TARGET)) begin
          match_winner_d = RES_DEALER;
          state_d        = MATCH_OVER;
        end else begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        hand_resetb = 1'b1;
        if (next_round) begin
          state_d = CLEAR;
        end
      end
      MATCH_OVER: begin
        hand_resetb = 1'b1;
        match_over  = 1'b1;
        if (start) begin
          clr_all        = 1'b1;
          last_result_d  = RES_NONE;
          match_winner_d = RES_NONE;
          state_d        = CLEAR;
        end
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_player_wins (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .clr        (clr_all),
    .en         (inc_player),
    .cnt        (player_wins)
  );

  sat_counter #(.CNT_W(CNT_W)) u_dealer_wins (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .clr        (clr_all),
    .en         (inc_dealer),
    .cnt        (dealer_wins)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ties (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .clr        (clr_all),
    .en         (inc_tie),
    .cnt        (ties)
  );

  sat_counter #(.CNT_W(CNT_W)) u_round_num (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .clr        (clr_all),
    .en         (inc_round),
    .cnt        (round_num)
  );

endmodule

`default_nettype wire

// File: tb/tb_baccarat_match_ctrl.sv
// ------------------------------------------------------------------
// tb_baccarat_match_ctrl: two configurations checked against a match model. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_baccarat_match_ctrl;

  localparam int WT_A [2] = '{5, 3};
  localparam int CW_A [2] = '{4, 2};
  localparam int TO_A [2] = '{15, 6};

  localparam int P_IDLE   = 0;
  localparam int P_CLEAR  = 1;
  localparam int P_DEAL   = 2;
  localparam int P_SETTLE = 3;
  localparam int P_SHOW   = 4;
  localparam int P_OVER   = 5;
  localparam int P_FAULT  = 6;

  typedef struct packed {
    int hrb; int lr; int pw; int dw; int ti; int rn; int mo; int mw; int bz; int ft;
  } outs_t;

  logic slow_clock = 1'b0;
  logic resetb;
  logic st_a [2];
  logic nr_a [2];
  logic pl_a [2];
  logic dl_a [2];

  logic       hrb0, mo0, bz0, ft0, hrb1, mo1, bz1, ft1;
  logic [1:0] lr0, mw0, lr1, mw1;
  logic [3:0] pw0, dw0, ti0, rn0;
  logic [1:0] pw1, dw1, ti1, rn1;

  always #5 slow_clock = ~slow_clock;

  baccarat_match_ctrl #(.WIN_TARGET(5), .CNT_W(4), .TIMEOUT(15)) dut0 (
    .slow_clock(slow_clock), .resetb(resetb), .start(st_a[0]), .next_round(nr_a[0]),
    .player_win_light(pl_a[0]), .dealer_win_light(dl_a[0]), .hand_resetb(hrb0),
    .last_result(lr0), .player_wins(pw0), .dealer_wins(dw0), .ties(ti0), .round_num(rn0),
    .match_over(mo0), .match_winner(mw0), .busy(bz0), .fault(ft0)
  );

  baccarat_match_ctrl #(.WIN_TARGET(3), .CNT_W(2), .TIMEOUT(6)) dut1 (
    .slow_clock(slow_clock), .resetb(resetb), .start(st_a[1]), .next_round(nr_a[1]),
    .player_win_light(pl_a[1]), .dealer_win_light(dl_a[1]), .hand_resetb(hrb1),
    .last_result(lr1), .player_wins(pw1), .dealer_wins(dw1), .ties(ti1), .round_num(rn1),
    .match_over(mo1), .match_winner(mw1), .busy(bz1), .fault(ft1)
  );

  // ---------------- behavioural match model ----------------
  int m_ph [2];
  int m_t  [2];
  int m_lr [2];
  int m_pw [2];
  int m_dw [2];
  int m_ti [2];
  int m_rn [2];
  int m_mw [2];

  function automatic int bump(input int v, input int i);
    int mx;
    mx = (1 << CW_A[i]) - 1;
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  function automatic int light_code(input int i);
    return 2 * int'(pl_a[i]) + int'(dl_a[i]);
  endfunction

  always @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 2; i++) begin
        m_ph[i] <= P_IDLE; m_t[i] <= 0; m_lr[i] <= 0; m_pw[i] <= 0;
        m_dw[i] <= 0; m_ti[i] <= 0; m_rn[i] <= 0; m_mw[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (m_ph[i])
          P_IDLE, P_OVER: begin
            if (st_a[i]) begin
              m_ph[i] <= P_CLEAR; m_lr[i] <= 0; m_pw[i] <= 0; m_dw[i] <= 0;
              m_ti[i] <= 0; m_rn[i] <= 0; m_mw[i] <= 0;
            end
          end
          P_CLEAR: begin
            m_ph[i] <= P_DEAL;
            m_t[i]  <= 0;
          end
          P_DEAL: begin
            if (light_code(i) != 0) begin
              m_lr[i] <= light_code(i);
              m_ph[i] <= P_SETTLE;
            end else if (m_t[i] == TO_A[i] - 1) begin
              m_ph[i] <= P_FAULT;
            end else begin
              m_t[i] <= m_t[i] + 1;
            end
          end
          P_SETTLE: begin
            if (m_lr[i] == 2) m_pw[i] <= bump(m_pw[i], i);
            if (m_lr[i] == 1) m_dw[i] <= bump(m_dw[i], i);
            if (m_lr[i] == 3) m_ti[i] <= bump(m_ti[i], i);
            m_rn[i] <= bump(m_rn[i], i);
            if (m_lr[i] == 2 && bump(m_pw[i], i) == WT_A[i]) begin
              m_mw[i] <= 2; m_ph[i] <= P_OVER;
            end else if (m_lr[i] == 1 && bump(m_dw[i], i) == WT_A[i]) begin
              m_mw[i] <= 1; m_ph[i] <= P_OVER;
            end else begin
              m_ph[i] <= P_SHOW;
            end
          end
          P_SHOW: begin
            if (nr_a[i]) m_ph[i] <= P_CLEAR;
          end
          default: ;
        endcase
      end
    end
  end

  function automatic outs_t exp_outs(input int i);
    outs_t o;
    o.hrb = (m_ph[i] == P_DEAL || m_ph[i] == P_SETTLE || m_ph[i] == P_SHOW || m_ph[i] == P_OVER) ? 1 : 0;
    o.bz  = (m_ph[i] == P_CLEAR || m_ph[i] == P_DEAL || m_ph[i] == P_SETTLE) ? 1 : 0;
    o.mo  = (m_ph[i] == P_OVER) ? 1 : 0;
    o.ft  = (m_ph[i] == P_FAULT) ? 1 : 0;
    o.lr  = m_lr[i]; o.pw = m_pw[i]; o.dw = m_dw[i];
    o.ti  = m_ti[i]; o.rn = m_rn[i]; o.mw = m_mw[i];
    return o;
  endfunction

  function automatic outs_t dut_outs(input int i);
    outs_t o;
    if (i == 0) begin
      o.hrb = int'(hrb0); o.lr = int'(lr0); o.pw = int'(pw0); o.dw = int'(dw0); o.ti = int'(ti0);
      o.rn = int'(rn0); o.mo = int'(mo0); o.mw = int'(mw0); o.bz = int'(bz0); o.ft = int'(ft0);
    end else begin
      o.hrb = int'(hrb1); o.lr = int'(lr1); o.pw = int'(pw1); o.dw = int'(dw1); o.ti = int'(ti1);
      o.rn = int'(rn1); o.mo = int'(mo1); o.mw = int'(mw1); o.bz = int'(bz1); o.ft = int'(ft1);
    end
    return o;
  endfunction

  // ---------------- checking and stimulus ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit directed;
  bit rnd_mode;
  int dir_res [2];
  int dir_dly [2];
  int e_cnt   [2];
  int e_res   [2];
  int e_dly   [2];

  task automatic chk(input int i, input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %0d, expected %0d at %0t", i, nm, act, exp, $time);
    end
  endtask

  task automatic compare_all(input int i, input outs_t e);
    outs_t o;
    o = dut_outs(i);
    chk(i, "hand_resetb", o.hrb, e.hrb);
    chk(i, "last_result", o.lr, e.lr);
    chk(i, "player_wins", o.pw, e.pw);
    chk(i, "dealer_wins", o.dw, e.dw);
    chk(i, "ties", o.ti, e.ti);
    chk(i, "round_num", o.rn, e.rn);
    chk(i, "match_over", o.mo, e.mo);
    chk(i, "match_winner", o.mw, e.mw);
    chk(i, "busy", o.bz, e.bz);
    chk(i, "fault", o.ft, e.ft);
  endtask

  // Hand emulator: lights dark while held in reset, result appears after a delay.
  task automatic emulate(input int i);
    if (dut_outs(i).hrb == 0) begin
      e_cnt[i] = 0;
      pl_a[i]  = 1'b0;
      dl_a[i]  = 1'b0;
      if (directed) begin
        e_res[i] = dir_res[i];
        e_dly[i] = dir_dly[i];
      end else begin
        e_res[i] = ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, 3));
        e_dly[i] = int'($urandom_range(0, unsigned'(TO_A[i] + 1)));
      end
    end else begin
      if (e_cnt[i] >= e_dly[i]) begin
        pl_a[i] = e_res[i][1];
        dl_a[i] = e_res[i][0];
      end
      e_cnt[i]++;
    end
  endtask

  task automatic cyc();
    @(negedge slow_clock);
    for (int i = 0; i < 2; i++) compare_all(i, exp_outs(i));
    for (int i = 0; i < 2; i++) emulate(i);
    if (rnd_mode) begin
      for (int i = 0; i < 2; i++) begin
        st_a[i] = ($urandom_range(0, 9) == 0);
        nr_a[i] = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  task automatic wait_settled(input int i);
    for (int k = 0; k < 40; k++) begin
      if (dut_outs(i).bz == 0) return;
      cyc();
    end
    n_cmp++;
    n_fail++;
    $display("FAIL inst%0d settle_wait: busy still 1 after 40 cycles, expected 0", i);
  endtask

  task automatic hand(input int i, input int res, input bit use_start);
    dir_res[i] = res;
    dir_dly[i] = 2;
    if (use_start) st_a[i] = 1'b1;
    else           nr_a[i] = 1'b1;
    cyc();
    st_a[i] = 1'b0;
    nr_a[i] = 1'b0;
    wait_settled(i);
  endtask

  initial begin
    resetb   = 1'b0;
    directed = 1'b1;
    rnd_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st_a[i] = 1'b0; nr_a[i] = 1'b0; pl_a[i] = 1'b0; dl_a[i] = 1'b0;
      dir_res[i] = 0; dir_dly[i] = 0; e_cnt[i] = 0; e_res[i] = 0; e_dly[i] = 0;
    end
    repeat (3) cyc();
    resetb = 1'b1;
    cyc();
    chk(0, "rst_hand_resetb", int'(hrb0), 0);
    chk(0, "rst_player_wins", int'(pw0), 0);
    chk(0, "rst_busy", int'(bz0), 0);
    chk(0, "rst_match_winner", int'(mw0), 0);

    // Single player hand: latency of hand_resetb and first tally.
    dir_res[0] = 2; dir_dly[0] = 5;
    st_a[0] = 1'b1;
    cyc();
    st_a[0] = 1'b0;
    chk(0, "edge1_hand_resetb", int'(hrb0), 0);
    chk(0, "edge1_busy", int'(bz0), 1);
    cyc();
    chk(0, "edge2_hand_resetb", int'(hrb0), 1);
    wait_settled(0);
    chk(0, "h1_last_result", int'(lr0), 2);
    chk(0, "h1_player_wins", int'(pw0), 1);
    chk(0, "h1_round_num", int'(rn0), 1);
    chk(0, "h1_show_hand_resetb", int'(hrb0), 1);

    // Small config: P D T P P reaches WIN_TARGET=3, round_num saturates at 3.
    hand(1, 2, 1'b1);
    hand(1, 1, 1'b0);
    hand(1, 3, 1'b0);
    hand(1, 2, 1'b0);
    hand(1, 2, 1'b0);
    chk(1, "m_player_wins", int'(pw1), 3);
    chk(1, "m_dealer_wins", int'(dw1), 1);
    chk(1, "m_ties", int'(ti1), 1);
    chk(1, "m_round_num", int'(rn1), 3);
    chk(1, "m_match_over", int'(mo1), 1);
    chk(1, "m_match_winner", int'(mw1), 2);
    nr_a[1] = 1'b1;
    repeat (3) cyc();
    nr_a[1] = 1'b0;
    chk(1, "over_ignores_next", int'(mo1), 1);

    // Restart from MATCH_OVER clears on the start edge; next_round in DEAL is inert.
    dir_res[1] = 0; dir_dly[1] = 0;
    st_a[1] = 1'b1;
    cyc();
    st_a[1] = 1'b0;
    chk(1, "restart_player_wins", int'(pw1), 0);
    chk(1, "restart_round_num", int'(rn1), 0);
    chk(1, "restart_match_winner", int'(mw1), 0);
    chk(1, "restart_busy", int'(bz1), 1);
    cyc();
    nr_a[1] = 1'b1;
    repeat (2) cyc();
    nr_a[1] = 1'b0;
    chk(1, "deal_ignores_next", int'(bz1), 1);

    // Watchdog on the default config: fault after exactly 15 DEAL cycles.
    dir_res[0] = 0; dir_dly[0] = 0;
    nr_a[0] = 1'b1;
    cyc();
    nr_a[0] = 1'b0;
    repeat (15) cyc();
    chk(0, "wd_before_fault", int'(ft0), 0);
    cyc();
    chk(0, "wd_fault", int'(ft0), 1);
    chk(0, "wd_hand_resetb", int'(hrb0), 0);
    st_a[0] = 1'b1;
    repeat (2) cyc();
    st_a[0] = 1'b0;
    chk(0, "fault_ignores_start", int'(ft0), 1);

    resetb = 1'b0;
    cyc();
    resetb = 1'b1;
    cyc();
    compare_all(0, '0);
    compare_all(1, '0);

    // Five ties then a player hand on the 2-bit config.
    hand(1, 3, 1'b1);
    for (int k = 0; k < 4; k++) hand(1, 3, 1'b0);
    hand(1, 2, 1'b0);
    chk(1, "sat_ties", int'(ti1), 3);
    chk(1, "sat_round_num", int'(rn1), 3);
    chk(1, "sat_player_wins", int'(pw1), 1);

    // Asynchronous reset in the middle of DEAL.
    dir_res[0] = 0; dir_dly[0] = 0;
    st_a[0] = 1'b1;
    cyc();
    st_a[0] = 1'b0;
    cyc();
    #2 resetb = 1'b0;
    #1;
    chk(0, "async_hand_resetb", int'(hrb0), 0);
    chk(0, "async_busy", int'(bz0), 0);
    cyc();
    resetb = 1'b1;

    directed = 1'b0;
    rnd_mode = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      cyc();
      if (k % 500 == 250) begin
        #2 resetb = 1'b0;
        cyc();
        resetb = 1'b1;
      end
    end
    rnd_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st_a[i] = 1'b0;
      nr_a[i] = 1'b0;
    end
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/baccarat_match_ctrl.md
Name: baccarat_match_ctrl

Overview:
- Match-level sequencer that sits above the per-hand baccarat state machine and its card datapath.
- Holds the hand logic in reset between hands, then releases it to play one hand.
- Detects the hand result from the player/dealer win lights, tallies results, and declares a match winner when one side reaches WIN_TARGET hand wins.
- Runs a watchdog so that a hand which never reports a result latches a fault.

Parameters:
- WIN_TARGET, 5: hand wins needed to win the match (1..2^CNT_W-1).
- CNT_W, 4: width of all tally and round counters.
- TIMEOUT, 15: maximum slow_clock cycles allowed in DEAL before a fault is declared.

Ports:
- slow_clock  in  1  system clock; all state changes on its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- start  in  1  begin a new match; honoured only in IDLE or MATCH_OVER.
- next_round  in  1  advance to the next hand; honoured only in SHOW.
- player_win_light  in  1  from the hand state machine.
- dealer_win_light  in  1  from the hand state machine.
- hand_resetb  out  1  active-low reset driven to the hand state machine and card registers.
- last_result  out  2  registered result of the last hand: 10 player, 01 dealer, 11 tie, 00 none.
- player_wins  out  CNT_W  player hand-win tally.
- dealer_wins  out  CNT_W  dealer hand-win tally.
- ties  out  CNT_W  tie tally.
- round_num  out  CNT_W  hands completed this match.
- match_over  out  1  high in MATCH_OVER.
- match_winner  out  2  10 player, 01 dealer, 00 undecided.
- busy  out  1  high in CLEAR, DEAL, SETTLE.
- fault  out  1  high in FAULT.

Behaviour:
- Reset (resetb=0, asynchronous): state=IDLE; all counters, last_result and match_winner = 0; hand_resetb=0; all other outputs 0.
- Result decode: result = {player_win_light, dealer_win_light}; 00 means pending.
- IDLE:
  - hand_resetb=0.
  - start=1 -> CLEAR; all tallies, round_num, last_result and match_winner clear on the same edge.
- CLEAR:
  - Exactly one cycle with hand_resetb=0, then DEAL.
  - The watchdog timer loads 0 on entry to DEAL.
- DEAL:
  - hand_resetb=1; the timer increments each cycle.
  - If result != 00, go to SETTLE and latch result into last_result on that edge.
  - Else if timer == TIMEOUT-1, go to FAULT.
  - A result and a timeout on the same cycle: the result wins.
- SETTLE (one cycle):
  - hand_resetb=1, so the hand state machine stays in its result state.
  - Using last_result: 10 increments player_wins, 01 increments dealer_wins, 11 increments ties.
  - round_num increments.
  - All counters saturate at 2^CNT_W-1 and never wrap.
  - If the post-increment player_wins or dealer_wins == WIN_TARGET: set match_winner accordingly and go to MATCH_OVER; else go to SHOW.
- SHOW:
  - hand_resetb=1, lights remain visible.
  - next_round=1 -> CLEAR; counters are held.
  - start is ignored.
- MATCH_OVER:
  - hand_resetb=1, match_over=1; counters and match_winner are held.
  - start=1 -> CLEAR with a full clear, as from IDLE.
  - next_round is ignored.
- FAULT:
  - hand_resetb=0, fault=1; counters are held.
  - Exits only via resetb; start and next_round are ignored.
- Latency: from start to hand_resetb rising is 2 edges (IDLE->CLEAR->DEAL).
- start and next_round are level-sampled on slow_clock. A level held high re-triggers only in states where it is honoured.
- resetb asserted mid-hand forces IDLE immediately and drives hand_resetb=0 asynchronously.

Decomposition:
- Shared package:
  - State enum: IDLE, CLEAR, DEAL, SETTLE, SHOW, MATCH_OVER, FAULT; 3-bit encoding.
  - Result codes RES_NONE=00, RES_DEALER=01, RES_PLAYER=10, RES_TIE=11.
- One sub-module, sat_counter: CNT_W-wide counter with synchronous clear, enable, and saturation at all-ones, reset by resetb.
  - Instantiated four times: player_wins, dealer_wins, ties, round_num.
- The watchdog timer and FSM live in baccarat_match_ctrl.

Test Plan:
- Reset, then start=1 for 1 cycle -> hand_resetb low at edge 1, high from edge 2; busy=1; a player result (10) after 5 cycles -> last_result=10, player_wins=1, round_num=1, state SHOW.
- WIN_TARGET=2; player, dealer, tie, player hands separated by next_round -> after the 4th hand player_wins=2, dealer_wins=1, ties=1, round_num=4, match_over=1, match_winner=10; further next_round is ignored.
- Result held at 00 with TIMEOUT=15 -> fault=1 on the 15th DEAL cycle; hand_resetb=0; start is ignored until resetb pulses, after which all outputs = 0.
- In MATCH_OVER assert start -> all counters and match_winner = 0 on the same edge, then a new hand is dealt; next_round=1 asserted in DEAL changes nothing.
- CNT_W=2, WIN_TARGET=3, feed 5 ties then a player win -> ties saturates at 3 and round_num saturates at 3.
- Assert resetb=0 mid-DEAL -> hand_resetb=0 immediately without a clock edge; state IDLE.
